note_match_judge: RTL
=====================

Name: note_match_judge

Overview:
- Upstream neighbour of the song player in learning (non-auto) mode.
- Compares the player's keyboard presses with the note currently shown on the 7 note lights and the high/low octave flags.
- Drives the player's match input: the player advances only while is_match is high.
- Keeps hit/miss statistics and a 2-bit performance grade for display.

Parameters:
- DEBOUNCE_CYCLES, 2_000_000, cycles a key vector must stay unchanged to be accepted (20 ms at 100 MHz).
- TIMEOUT_CYCLES, 300_000_000, cycles allowed for a correct press before a miss is charged (3 s).
- CNT_W, 8, width of the hit/miss counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  learning mode active (player not in auto mode)
- target_lights  in  7  one-hot note under display; 0 = rest
- target_high  in  1  displayed note is high octave
- target_low  in  1  displayed note is low octave
- keys  in  7  raw note buttons, asynchronous
- oct_high  in  1  raw high-octave switch
- oct_low  in  1  raw low-octave switch
- is_match  out  1  player may advance
- hit_count  out  CNT_W  correct notes
- miss_count  out  CNT_W  wrong presses plus timeouts
- grade  out  2  3 = perfect, 2 = good, 1 = fair, 0 = poor
- hint_lights  out  7  hint display; 0 when the hint feature is compiled out

Behaviour:
- Input conditioning:
  - keys, oct_high and oct_low pass through a 2-FF synchroniser.
  - The 9-bit vector is then debounced: it is accepted after DEBOUNCE_CYCLES consecutive identical samples.
  - Input-to-use latency is 2 + DEBOUNCE_CYCLES cycles.
- Expected octave: {target_high, target_low}. The press octave is {oct_high, oct_low} from the debounced vector.
- A press is correct when debounced keys == target_lights, the press octave equals the expected octave, and target_lights != 0.
- States (registered):
  - IDLE: is_match = 0. Enters WAIT when enable = 1.
  - WAIT: the timeout counter runs.
    - Correct press -> HIT; hit_count++.
    - Debounced keys nonzero and not correct -> WRONG; miss_count++.
    - target_lights == 0 (rest) -> REST.
    - Timeout counter reaches TIMEOUT_CYCLES-1 -> miss_count++, counter clears, stays in WAIT.
  - HIT: is_match = 1.
    - Stays while target_lights is unchanged.
    - Any change of target_lights (sampled against a 1-cycle delayed copy) -> RELEASE.
  - RELEASE: is_match = 0.
    - Goes to WAIT once debounced keys == 0.
    - A stale held key is never scored twice.
  - WRONG: is_match = 0.
    - Goes to WAIT when debounced keys == 0; timeout counter clears.
  - REST: is_match = 1, so rests pass automatically.
    - Goes to WAIT when target_lights becomes nonzero.
- enable = 0 in any state -> IDLE next cycle.
  - Counters and grade hold.
  - Debounce and timeout counters clear.
- Rising edge of enable clears hit_count and miss_count (new song attempt).
- Counters saturate at 2^CNT_W-1 and never wrap.
- grade is registered and updated every cycle. The first matching rule wins:
  - miss_count == 0 and hit_count != 0 -> 3
  - 4*miss_count <= hit_count -> 2
  - miss_count <= hit_count -> 1
  - otherwise -> 0
  - Compare at CNT_W+2 bits.
- Simultaneous events in WAIT: a correct press beats a timeout in the same cycle (hit only, no miss).
- Reset, including mid-note:
  - State goes to IDLE.
  - is_match = 0, hit_count = 0, miss_count = 0, grade = 0, hint_lights = 0.
  - Synchroniser, debounce and timeout registers clear.

Optional Feature:
- Macro: MATCH_HINT_EN.
- Defined:
  - After the first timeout on the current note, hint_lights blinks target_lights at 2 Hz (toggle every 25_000_000 cycles; phase counter is in-module).
  - Cleared to 0 on leaving WAIT, on enable = 0 and on reset.
- Undefined: hint_lights is tied to 0 and no blink logic is generated.

Decomposition:
- Shared package (with the existing note/frequency constants):
  - state encoding localparams: IDLE, WAIT, HIT, RELEASE, WRONG, REST
  - grade constants: GRADE_PERFECT/GOOD/FAIR/POOR
  - NOTE_W = 7
- One sub-module, vec_debounce (parameters WIDTH and CYCLES; ports clk, rst, din, dout). Instantiate it once on the 9-bit vector.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100):
- Correct press: enable=1, target_lights=7'b0010000 (mi, mid octave), keys=7'b0010000 held 10 cycles -> is_match=1 exactly 6 cycles after keys change; hit_count=1, miss_count=0, grade=3.
- Debounce: keys toggle every 2 cycles for 20 cycles -> no state change, counts stay 0.
- Wrong press: target=7'b1000000 with target_high=1, keys=7'b1000000, oct switches 0 -> miss_count=1, is_match=0. Holding 50 cycles adds no further miss. Release, then press with oct_high=1 -> hit_count=1.
- Timeout and saturation: target held, no keys for 250 cycles -> miss_count=2 at cycles 100 and 200. Force 300 timeouts -> miss_count sticks at 255.
- Note advance and rests: after HIT, target changes to 0 while the key is still held -> RELEASE, is_match=0. After release, REST gives is_match=1. Same-cycle correct press and timeout -> hit_count+1, miss unchanged.
- Reset: rst pulsed in HIT with hit_count=5 -> next cycle all outputs 0 and state IDLE. With MATCH_HINT_EN defined, hint_lights=target after the first timeout and toggles every 25_000_000 cycles.

Source files
------------

// File: rtl/note_match_judge_pkg.sv
// Shared constants for the learning-mode note judge: note light encodings,
// mid-octave note frequencies, FSM state encoding and grade values.
package note_match_judge_pkg;

    localparam int NOTE_W    = 7;
    localparam int OCT_W     = 2;
    localparam int KEY_VEC_W = NOTE_W + OCT_W;

    // One-hot note lights, do on the leftmost light
    localparam logic [NOTE_W-1:0] NOTE_DO  = 7'b1000000;
    localparam logic [NOTE_W-1:0] NOTE_RE  = 7'b0100000;
    localparam logic [NOTE_W-1:0] NOTE_MI  = 7'b0010000;
    localparam logic [NOTE_W-1:0] NOTE_FA  = 7'b0001000;
    localparam logic [NOTE_W-1:0] NOTE_SOL = 7'b0000100;
    localparam logic [NOTE_W-1:0] NOTE_LA  = 7'b0000010;
    localparam logic [NOTE_W-1:0] NOTE_SI  = 7'b0000001;

    // Mid-octave note frequencies in Hz
    localparam int FREQ_DO  = 262;
    localparam int FREQ_RE  = 294;
    localparam int FREQ_MI  = 330;
    localparam int FREQ_FA  = 349;
    localparam int FREQ_SOL = 392;
    localparam int FREQ_LA  = 440;
    localparam int FREQ_SI  = 494;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        HIT     = 3'd2,
        RELEASE = 3'd3,
        WRONG   = 3'd4,
        REST    = 3'd5
    } state_t;

    localparam logic [1:0] GRADE_PERFECT = 2'd3;
    localparam logic [1:0] GRADE_GOOD    = 2'd2;
    localparam logic [1:0] GRADE_FAIR    = 2'd1;
    localparam logic [1:0] GRADE_POOR    = 2'd0;

    // Half period of the 2 Hz hint blink at 100 MHz
    localparam int HINT_HALF_PERIOD = 25_000_000;

endpackage

// File: rtl/note_match_judge_debounce.sv
// Vector debouncer: dout follows din once din has held one value for CYCLES
// consecutive samples. The synchroniser flop that presents din counts as the
// first sample, so dout changes CYCLES-1 edges after din does and a registered
// consumer acts CYCLES cycles after the synchroniser output changes.
// CYCLES must be at least 2.
module vec_debounce #(
    parameter int WIDTH  = 9,
    parameter int CYCLES = 2_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    run;

    // Count samples of the current candidate; accept it when the run is long enough
    always_comb begin
        cand_d = din;
        dout_d = dout_q;
        cnt_d  = '0;
        run    = (din != cand_q) ? CW'(1) : cnt_q + CW'(1);
        if (din != dout_q) begin
            if (run == CW'(CYCLES - 1)) begin
                dout_d = din;
            end else begin
                cnt_d = run;
            end
        end
    end

    // Candidate, run length and accepted value registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q <= '0;
            dout_q <= '0;
            cnt_q  <= '0;
        end else begin
            cand_q <= cand_d;
            dout_q <= dout_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/note_match_judge.sv
// Learning-mode note judge: compares debounced key/octave presses with the
// displayed note, gates the song player through is_match and keeps hit/miss
// statistics with a performance grade.
// Optional blink hint on timeout: define MATCH_HINT_EN.
module note_match_judge
    import note_match_judge_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int TIMEOUT_CYCLES  = 300_000_000,
    parameter int CNT_W           = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [6:0]        target_lights,
    input  logic              target_high,
    input  logic              target_low,
    input  logic [6:0]        keys,
    input  logic              oct_high,
    input  logic              oct_low,
    output logic              is_match,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
    output logic [1:0]        grade,
    output logic [6:0]        hint_lights
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES);

    logic [KEY_VEC_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d, deb_vec;
    logic                 deb_rst;
    logic [NOTE_W-1:0]    d_keys, tgt_prev_q, tgt_prev_d;
    logic [1:0]           press_oct;
    logic                 correct, timeout;
    state_t               state_q, state_d;
    logic [TO_W-1:0]      to_q, to_d;
    logic [CNT_W-1:0]     hit_q, hit_d, miss_q, miss_d;
    logic                 hit_inc, miss_inc;
    logic                 en_q, en_d, en_rise;
    logic [1:0]           grade_q, grade_d;
    logic [CNT_W+1:0]     h_ext, m_ext;

    // Two-stage synchroniser on the raw key/octave vector
    always_comb begin
        sync1_d = {oct_high, oct_low, keys};
        sync2_d = sync1_q;
    end

    // Debounce is held in reset while learning mode is off
    assign deb_rst = rst | ~enable;

    vec_debounce #(
        .WIDTH  (KEY_VEC_W),
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst  (deb_rst),
        .din  (sync2_q),
        .dout (deb_vec)
    );

    assign d_keys    = deb_vec[NOTE_W-1:0];
    assign press_oct = deb_vec[KEY_VEC_W-1 -: 2];
    assign correct   = (d_keys == target_lights) &&
                       (press_oct == {target_high, target_low}) &&
                       (target_lights != '0);
    assign timeout   = (to_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign en_rise   = enable & ~en_q;
    assign tgt_prev_d = target_lights;
    assign en_d       = enable;

    // Judge FSM: next state, timeout counter and scoring events
    always_comb begin
        state_d  = state_q;
        to_d     = '0;
        hit_inc  = 1'b0;
        miss_inc = 1'b0;
        case (state_q)
            IDLE: state_d = WAIT;
            WAIT: begin
                to_d = to_q + TO_W'(1);
                if (correct) begin
                    state_d = HIT;
                    hit_inc = 1'b1;
                end else if (d_keys != '0) begin
                    state_d  = WRONG;
                    miss_inc = 1'b1;
                end else if (target_lights == '0) begin
                    state_d = REST;
                end else if (timeout) begin
                    miss_inc = 1'b1;
                    to_d     = '0;
                end
            end
            HIT:     if (target_lights != tgt_prev_q) state_d = RELEASE;
            RELEASE: if (d_keys == '0) state_d = WAIT;
            WRONG:   if (d_keys == '0) state_d = WAIT;
            REST:    if (target_lights != '0) state_d = WAIT;
            default: state_d = IDLE;
        endcase
        if (state_d != WAIT) to_d = '0;
        if (!enable) begin
            state_d  = IDLE;
            to_d     = '0;
            hit_inc  = 1'b0;
            miss_inc = 1'b0;
        end
    end

    // Saturating statistics, cleared when a new attempt starts
    always_comb begin
        hit_d  = hit_q;
        miss_d = miss_q;
        if (en_rise) begin
            hit_d  = '0;
            miss_d = '0;
        end else begin
            if (hit_inc && !(&hit_q))   hit_d  = hit_q + CNT_W'(1);
            if (miss_inc && !(&miss_q)) miss_d = miss_q + CNT_W'(1);
        end
    end

    // Grade from current counts, first matching rule wins
    always_comb begin
        h_ext = {2'b00, hit_q};
        m_ext = {2'b00, miss_q};
        if (miss_q == '0 && hit_q != '0) begin
            grade_d = GRADE_PERFECT;
        end else if ((m_ext << 2) <= h_ext) begin
            grade_d = GRADE_GOOD;
        end else if (m_ext <= h_ext) begin
            grade_d = GRADE_FAIR;
        end else begin
            grade_d = GRADE_POOR;
        end
    end

    // State, counters and input pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            state_q    <= IDLE;
            to_q       <= '0;
            hit_q      <= '0;
            miss_q     <= '0;
            grade_q    <= GRADE_POOR;
            en_q       <= 1'b0;
            tgt_prev_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            state_q    <= state_d;
            to_q       <= to_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            grade_q    <= grade_d;
            en_q       <= en_d;
            tgt_prev_q <= tgt_prev_d;
        end
    end

    assign is_match   = (state_q == HIT) || (state_q == REST);
    assign hit_count  = hit_q;
    assign miss_count = miss_q;
    assign grade      = grade_q;

`ifdef MATCH_HINT_EN
    localparam int PH_W = $clog2(HINT_HALF_PERIOD);

    logic            armed_q, armed_d, hint_on_q, hint_on_d, tmo_evt;
    logic [PH_W-1:0] ph_q, ph_d;

    // A timeout taken in WAIT is the only way WAIT stays WAIT with the counter at its limit
    assign tmo_evt = (state_q == WAIT) && (state_d == WAIT) && timeout;

    // Arm on first timeout of the note, then blink at the half period
    always_comb begin
        armed_d   = armed_q;
        hint_on_d = hint_on_q;
        ph_d      = ph_q;
        if (tmo_evt && !armed_q) begin
            armed_d   = 1'b1;
            hint_on_d = 1'b1;
            ph_d      = '0;
        end else if (armed_q) begin
            if (ph_q == PH_W'(HINT_HALF_PERIOD - 1)) begin
                ph_d      = '0;
                hint_on_d = ~hint_on_q;
            end else begin
                ph_d = ph_q + PH_W'(1);
            end
        end
        if (state_d != WAIT) begin
            armed_d   = 1'b0;
            hint_on_d = 1'b0;
            ph_d      = '0;
        end
    end

    // Hint blink registers
    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q   <= 1'b0;
            hint_on_q <= 1'b0;
            ph_q      <= '0;
        end else begin
            armed_q   <= armed_d;
            hint_on_q <= hint_on_d;
            ph_q      <= ph_d;
        end
    end

    assign hint_lights = hint_on_q ? target_lights : '0;
`else
    assign hint_lights = '0;
`endif

endmodule
